// File: rtl/alu_mc_pkg.sv
// Shared opcode, FSM-state and flag definitions for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_DIVU = 4'd8;
    localparam logic [3:0] OP_REMU = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic carry;
        logic negative;
    } flags_t;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle of the multi-cycle ALU; slave is the ALU side.
interface alu_mc_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   f;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             carry;
    logic             negative;

    modport master (
        output in_valid, a, b, f, out_ready,
        input  in_ready, out_valid, result, zero, overflow, carry, negative
    );

    modport slave (
        input  in_valid, a, b, f, out_ready,
        output in_ready, out_valid, result, zero, overflow, carry, negative
    );
endinterface

// File: rtl/alu_mc_muldiv.sv
// Iterative unsigned MUL/DIVU/REMU engine, one step per cycle for WIDTH cycles.
// done/res/ovf are combinational in the final step cycle; no backpressure (caller must capture).
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic               busy_q,  busy_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic [3:0]         op_q,    op_d;
    logic [WIDTH-1:0]   opnd_q,  opnd_d;
    logic [2*WIDTH-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0]   shr_q,   shr_d;
    logic [WIDTH-1:0]   rem_q,   rem_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;

    // Multiplier lives in the low half of acc and is consumed LSB first.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh   = {rem_q, shr_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        // rem_sh < 2*divisor, so the borrow bit alone decides restore vs. subtract.
        ge       = ~rem_diff[WIDTH];
        rem_step = ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_step = {shr_q[WIDTH-2:0], ge};
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        opnd_d = opnd_q;
        acc_d  = acc_q;
        shr_d  = shr_q;
        rem_d  = rem_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            op_d   = op;
            opnd_d = (op == OP_MUL) ? a : b;
            acc_d  = {{WIDTH{1'b0}}, b};
            shr_d  = a;
            rem_d  = '0;
        end else if (busy_q) begin
            cnt_d = cnt_q + 1'b1;
            if (op_q == OP_MUL) begin
                acc_d = acc_step;
            end else begin
                rem_d = rem_step;
                shr_d = quo_step;
            end
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= '0;
            opnd_q <= '0;
            acc_q  <= '0;
            shr_q  <= '0;
            rem_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            opnd_q <= opnd_d;
            acc_q  <= acc_d;
            shr_q  <= shr_d;
            rem_q  <= rem_d;
        end
    end

    assign done = busy_q && (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        res = '0;
        ovf = 1'b0;
        if (op_q == OP_MUL) begin
            res = acc_step[WIDTH-1:0];
            ovf = |acc_step[2*WIDTH-1:WIDTH];
        end else begin
            res = (op_q == OP_REMU) ? rem_step : quo_step;
            ovf = (opnd_q == '0);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered result+flags, latency 1 (single-cycle ops) or WIDTH+1 (MUL/DIVU/REMU).
// Result held while out_ready is low; in_ready drops in BUSY and in DONE without out_ready.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  io
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;

    logic [OPW-1:0]   op;
    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             multi;
    logic             start;
    logic             load;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH-1:0] res_sel;
    logic             v_sel;
    logic             c_sel;

    logic             eng_done;
    logic [WIDTH-1:0] eng_res;
    logic             eng_ovf;

    assign op = io.f;

    always_comb begin
        b_eff   = (op == OP_SUB) ? ~io.b : io.b;
        sum     = {1'b0, io.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                // Using b_eff covers both ADD and SUB overflow rules.
                alu_v   = (io.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != io.a[WIDTH-1]);
            end
            OP_AND:  alu_res = io.a & io.b;
            OP_OR:   alu_res = io.a | io.b;
            OP_XOR:  alu_res = io.a ^ io.b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(io.a) < $signed(io.b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (io.a < io.b)};
            default: alu_res = '0;
        endcase
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (io.a),
        .b     (io.b),
        .done  (eng_done),
        .res   (eng_res),
        .ovf   (eng_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = multi ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                if (eng_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (io.out_ready) begin
                    if (accept) state_d = multi ? ST_BUSY : ST_DONE;
                    else        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && io.out_ready);
        out_valid = (state_q == ST_DONE);
        accept    = io.in_valid && in_ready;
        multi     = is_multi(op);
        start     = accept && multi;
        load      = (accept && !multi) || ((state_q == ST_BUSY) && eng_done);
    end

    always_comb begin
        res_sel = alu_res;
        v_sel   = alu_v;
        c_sel   = alu_c;
        if (state_q == ST_BUSY) begin
            res_sel = eng_res;
            v_sel   = eng_ovf;
            c_sel   = 1'b0;
        end
        result_d = result_q;
        flags_d  = flags_q;
        if (load) begin
            result_d         = res_sel;
            flags_d.zero     = (res_sel == '0);
            flags_d.overflow = v_sel;
            flags_d.carry    = c_sel;
            flags_d.negative = res_sel[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid;
    assign io.result    = result_q;
    assign io.zero      = flags_q.zero;
    assign io.overflow  = flags_q.overflow;
    assign io.carry     = flags_q.carry;
    assign io.negative  = flags_q.negative;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboarded directed test of alu_mc at WIDTH=32.
module tb_alu_mc;
    import alu_pkg::*;

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic [3:0]  flg;   // {zero, overflow, carry, negative}
    } exp_t;

    typedef struct {
        string       nm;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        bit          poke;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    exp_t sb [$];
    vec_t vecs [15];

    alu_mc_if #(.WIDTH(32), .OPW(4)) bus ();

    alu_mc #(.WIDTH(32), .OPW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every handover pops the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: got result 0x%0h with nothing expected", bus.result);
                end else begin
                    e = sb.pop_front();
                    chk({e.nm, "_res"}, 64'(bus.result), 64'(e.res));
                    chk({e.nm, "_flags"}, 64'({bus.zero, bus.overflow, bus.carry, bus.negative}), 64'(e.flg));
                end
            end
        end
    end

    task automatic send(input string nm, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] er, input logic [3:0] ef,
                        input bit push);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.f        = op;
        bus.a        = av;
        bus.b        = bv;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (push) begin
                    e.nm  = nm;
                    e.res = er;
                    e.flg = ef;
                    sb.push_back(e);
                end
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL %s_accept: in_ready stayed 0 for 100 cycles, want 1", nm);
        bus.in_valid = 1'b0;
    endtask

    // Counts cycles from accept to out_valid; optionally drives junk requests meanwhile.
    task automatic wait_valid(input string nm, input int exp_lat, input bit chk_busy, input bit poke);
        int lat;
        int bad;
        lat = 0;
        bad = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
            if (bus.in_ready) bad++;
            if (poke) begin
                bus.in_valid = 1'b1;
                bus.f        = OP_ADD;
                bus.a        = 32'd1;
                bus.b        = 32'd1;
            end
        end
        bus.in_valid = 1'b0;
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        if (chk_busy) chk({nm, "_busy_in_ready_hits"}, 64'(bad), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.f         = '0;
        bus.out_ready = 1'b1;

        vecs = '{
            '{"add_ovf",    OP_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b0101, 1,  1'b0},
            '{"sub_eq",     OP_SUB,  32'd5,         32'd5,         32'h0,         4'b1010, 1,  1'b0},
            '{"slt",        OP_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         4'b0000, 1,  1'b0},
            '{"sltu",       OP_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1000, 1,  1'b0},
            '{"sub_borrow", OP_SUB,  32'h0,         32'h1,         32'hFFFF_FFFF, 4'b0001, 1,  1'b0},
            '{"add_carry",  OP_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1010, 1,  1'b0},
            '{"xor",        OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000, 1,  1'b0},
            '{"or",         OP_OR,   32'h00F0_000F, 32'h0F00_0F00, 32'h0FF0_0F0F, 4'b0000, 1,  1'b0},
            '{"undef",      4'd12,   32'h1234_5678, 32'h9ABC_DEF0, 32'h0,         4'b1000, 1,  1'b0},
            '{"mul_hi",     OP_MUL,  32'h0001_0000, 32'h0001_0000, 32'h0,         4'b1100, 33, 1'b0},
            '{"mul_small",  OP_MUL,  32'd6,         32'd7,         32'd42,        4'b0000, 33, 1'b0},
            '{"divu",       OP_DIVU, 32'd100,       32'd7,         32'd14,        4'b0000, 33, 1'b1},
            '{"remu",       OP_REMU, 32'd100,       32'd7,         32'd2,         4'b0000, 33, 1'b0},
            '{"divu_z",     OP_DIVU, 32'd9,         32'd0,         32'hFFFF_FFFF, 4'b0101, 33, 1'b0},
            '{"remu_z",     OP_REMU, 32'd9,         32'd0,         32'd9,         4'b0100, 33, 1'b0}
        };

        #12;
        chk("reset_out", 64'({bus.out_valid, bus.result, bus.zero, bus.overflow, bus.carry, bus.negative}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            send(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg, 1'b1);
            wait_valid(vecs[i].nm, vecs[i].lat, vecs[i].lat > 1, vecs[i].poke);
        end

        // Backpressure: 0x12345678 + 0x0F0F0F0F = 0x21436587, no flags.
        bus.out_ready = 1'b0;
        send("bp_add", OP_ADD, 32'h1234_5678, 32'h0F0F_0F0F, 32'h2143_6587, 4'b0000, 1'b1);
        wait_valid("bp_add", 1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", 64'({bus.result, bus.zero, bus.overflow, bus.carry, bus.negative,
                                bus.in_ready, bus.out_valid}),
                64'({32'h2143_6587, 4'b0000, 1'b0, 1'b1}));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send("b2b_and", OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 4'b0000, 1'b1);
        wait_valid("b2b_and", 1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a multiply; no result expected from it.
        send("mul_rst", OP_MUL, 32'd3, 32'd5, 32'd15, 4'b0000, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midbusy_reset", 64'({bus.out_valid, bus.result, bus.zero, bus.overflow, bus.carry, bus.negative}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        send("add_after_rst", OP_ADD, 32'd2, 32'd3, 32'd5, 4'b0000, 1'b1);
        wait_valid("add_after_rst", 1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU, the successor to the team's 3-bit-opcode combinational ALU. It adds registered outputs, a valid/ready handshake on both sides, extra logic and compare ops, and iterative unsigned multiply/divide. It sits between the decode/operand stage and writeback of the datapath. Flag semantics (zero, overflow, carry, negative) carry over from the previous generation.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4)
OPW, 4, opcode width in bits (fixed at 4; any other value is illegal)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/opcode valid
in_ready  output  1  block accepts a request this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
f  input  OPW  opcode
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero  output  1  result == 0
overflow  output  1  signed overflow / mul high-half nonzero / divide-by-zero
carry  output  1  adder carry-out
negative  output  1  result[WIDTH-1]

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB (a + ~b + 1), 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed), 6 SLTU.
  - 7 MUL (low WIDTH bits of unsigned a*b), 8 DIVU (quotient), 9 REMU (remainder).
  - 10–15 undefined: result 0, all flags 0 except zero=1.
- Flags:
  - ADD: carry = adder carry-out; overflow = (a.msb==b.msb) && (res.msb!=a.msb).
  - SUB: carry = carry-out of a + ~b + 1 (1 means no borrow); overflow = (a.msb!=b.msb) && (res.msb!=a.msb).
  - Logic and compare ops: carry=0, overflow=0.
  - MUL: carry=0; overflow=1 iff the upper WIDTH bits of the full product are nonzero.
  - DIVU/REMU: carry=0; overflow=1 iff b==0.
  - negative = result msb and zero = (result==0) for every op. All flags are registered with result.
- Divide by zero: DIVU returns all-ones; REMU returns a.
- FSM states:
  - IDLE: no result held.
  - BUSY: iterative op running; cycle counter 0..WIDTH-1.
  - DONE: result held.
- Handshake:
  - A request is accepted when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Result handover happens when out_valid && out_ready.
  - out_valid = (state==DONE).
  - result and flags are stable while out_valid && !out_ready.
- Transitions:
  - IDLE, accept of a single-cycle op (0–6, 10–15): compute combinationally, register result/flags, go to DONE. out_valid is high the next cycle (latency 1).
  - IDLE, accept of op 7–9: latch a, b, f; clear the accumulator; go to BUSY.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIV) step per cycle for exactly WIDTH cycles, then register result and flags and go to DONE. Latency is WIDTH+1 cycles from accept to out_valid.
  - DONE with out_ready and a simultaneous new accept: behaves as the IDLE accept rules in the same cycle (back-to-back throughput of 1/cycle for single-cycle ops).
  - DONE with out_ready and no accept: go to IDLE.
  - No cancellation: in_valid is ignored while in BUSY.
- Reset, asynchronous, including mid-BUSY:
  - state=IDLE, counter=0, result=0, all flags=0, out_valid=0.
  - in_ready=1 once reset is released.
- Width rules:
  - Adder is WIDTH+1 bits.
  - Multiply accumulator is 2*WIDTH bits.
  - Division uses a WIDTH+1-bit partial remainder.
  - Counter is $clog2(WIDTH)+1 bits.

Decomposition:
- Package alu_pkg holds the opcode localparams (OP_ADD..OP_REMU), the FSM state encoding (ST_IDLE, ST_BUSY, ST_DONE), and a function classifying an op as multi-cycle.
- Sub-module alu_muldiv_iter is the iterative engine: start, op, a, b in; done, res, ovf out; WIDTH parameter.
- alu_mc holds the combinational ALU, the FSM, the handshake, and the output registers.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF+1, out_ready=1 -> next cycle out_valid=1, result 0x80000000, overflow=1, negative=1, carry=0, zero=0.
- SUB 5-5 -> result 0, zero=1, carry=1, overflow=0. SLT a=0xFFFFFFFF b=1 -> result 1. SLTU with the same operands -> result 0.
- MUL 0x10000 * 0x10000 -> out_valid exactly 33 cycles after accept, result 0, overflow=1, zero=1. in_ready=0 throughout BUSY.
- DIVU 100/7 -> 14. REMU 100/7 -> 2. DIVU 9/0 -> 0xFFFFFFFF with overflow=1. REMU 9/0 -> 9.
- Back-pressure: ADD result held with out_ready=0 for 5 cycles -> result and flags stable, in_ready=0. Raising out_ready with in_valid (AND op) -> handover and accept in the same cycle; new result on the next cycle.
- rst_n pulsed low mid-MUL (cycle 10) -> out_valid=0 and result=0 immediately (async). After release, in_ready=1; a new ADD 2+3 -> 5 with latency 1.
